// File: rtl/can_rx_fifo.sv
// can_rx_fifo: receive-frame queue with ID acceptance filter.
//
// Captures CRC-valid frames from the CAN receiver, drops frames rejected by
// the CODE/MASK filter, and queues accepted frames in a DEPTH-entry FIFO.
// The oldest frame is exposed through a 32-bit register window.
//
// Optional feature macro: CAN_RXF_FILTER_EN (CODE/MASK registers and the
// acceptance filter). When undefined, every frame_valid is a push candidate
// and rs 4/5 read as zero.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   frame_valid     one-cycle pulse, frame complete and CRC-valid
//   frame_id[28:0]  received ID (standard IDs right-aligned)
//   frame_ext       extended-frame flag
//   frame_rtr       remote-frame flag
//   frame_dlc[3:0]  data length code
//   frame_data[63:0] payload, byte n at [8n+7:8n]
//   cs, we, rs[2:0], d[31:0]  register access (32-bit only)
//   q[31:0]         combinational read data, 0 unless cs & ~we
//   irq             level interrupt = irqen & nempty
module can_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_valid,
  input  logic [28:0] frame_id,
  input  logic        frame_ext,
  input  logic        frame_rtr,
  input  logic [3:0]  frame_dlc,
  input  logic [63:0] frame_data,
  input  logic        cs,
  input  logic        we,
  input  logic [2:0]  rs,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        irq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry layout: {ext, rtr, dlc[3:0], id[28:0], data[63:0]}
  logic [98:0]   mem [DEPTH];
  logic [98:0]   head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf, irqen;
  logic          nempty, full;
  logic          reg_wr, stat_wr, pop_req, flush, clr_ovf;
  logic          accept, do_push, do_pop, ovf_set;
  logic          unused_bits;

  assign unused_bits = ^d[30:3];

  assign nempty  = (count != '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rptr];

  assign reg_wr  = cs & we;
  assign stat_wr = reg_wr & (rs == 3'd1);
  assign pop_req = stat_wr & d[0];
  assign flush   = stat_wr & d[1];
  assign clr_ovf = stat_wr & d[2];

`ifdef CAN_RXF_FILTER_EN
  logic [29:0] code, mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= '0;
      mask <= '0;
    end else begin
      if (reg_wr && rs == 3'd4) code <= d[29:0];
      if (reg_wr && rs == 3'd5) mask <= d[29:0];
    end
  end

  // Registered CODE/MASK: a write in the frame_valid cycle is not yet visible.
  assign accept = frame_valid & ((({frame_ext, frame_id} ^ code) & mask) == '0);
`else
  assign accept = frame_valid;
`endif

  // Flush overrides everything; a pop frees the slot a full-FIFO push needs.
  assign do_pop  = pop_req & nempty & ~flush;
  assign do_push = accept & ~flush & (~full | do_pop);
  assign ovf_set = accept & ~flush & full & ~do_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      irqen <= 1'b0;
    end else begin
      if (stat_wr) irqen <= d[31];
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_push) wptr <= wptr + PW'(1);
        if (do_pop)  rptr <= rptr + PW'(1);
        if (do_push && !do_pop)      count <= count + CW'(1);
        else if (!do_push && do_pop) count <= count - CW'(1);
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr] <= {frame_ext, frame_rtr, frame_dlc, frame_id, frame_data};
  end

  always_comb begin
    q = '0;
    if (cs && !we) begin
      case (rs)
        3'd0: if (nempty) q = {head[98], head[97], 1'b0, head[92:64]};
        3'd1: q = {irqen, 12'h0, ovf, full, nempty, 8'h0, 4'(count),
                   nempty ? head[96:93] : 4'h0};
        3'd2: if (nempty) q = head[31:0];
        3'd3: if (nempty) q = head[63:32];
`ifdef CAN_RXF_FILTER_EN
        3'd4: q = {2'b00, code};
        3'd5: q = {2'b00, mask};
`endif
        default: q = '0;
      endcase
    end
  end

  assign irq = irqen & nempty;

endmodule

// File: doc/can_rx_fifo.md
# can_rx_fifo

Receive-frame queue and acceptance filter that sits directly downstream of the CAN controller's receiver. It captures every completed, CRC-valid frame the receiver reports and drops frames rejected by an ID code/mask filter. It holds accepted frames in a DEPTH-entry FIFO and exposes the oldest one to the TinyQV core through a small 32-bit register window. This lets the core tolerate back-to-back frames that the controller's single receive buffer would overwrite.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..8.
- clk  in  1  system clock (64 MHz typical).
- rst_n  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle pulse from the receiver: a CRC-valid frame is complete.
- frame_id  in  29  received ID; standard IDs are right-aligned in [10:0].
- frame_ext  in  1  extended-frame flag.
- frame_rtr  in  1  remote-frame flag.
- frame_dlc  in  4  data length code.
- frame_data  in  64  payload; byte n at [8n+7:8n].
- cs  in  1  register access strobe; 32-bit accesses only.
- we  in  1  1 = write, 0 = read (qualified by cs).
- rs  in  3  register select.
- d  in  32  write data.
- q  out  32  read data; combinational; 0 when not (cs & ~we).
- irq  out  1  interrupt request, level.

## Operation
- Registers (rs):
  - 0: head ID = {ext, rtr, 1'b0, id[28:0]}.
  - 1: STATUS = {irqen[31], 12'h0, ovf[18], full[17], nempty[16], 8'h0, count[7:4], dlc[3:0]}.
  - 2: head data bytes 3..0.
  - 3: head data bytes 7..4.
  - 4: filter CODE = {2'b0, ext, id[28:0]}.
  - 5: filter MASK in the same layout.
  - 6, 7: read 0, writes ignored.
- Reading rs 0, 2 or 3 when the FIFO is empty returns 0.
- STATUS write command bits:
  - d[0]: pop the head; ignored when the FIFO is empty.
  - d[1]: flush, count set to 0.
  - d[2]: clear ovf.
  - d[31]: written into irqen.
- Acceptance rule: accept iff ((frame_id ^ CODE[28:0]) & MASK[28:0]) == 0 and ((frame_ext ^ CODE[29]) & MASK[29]) == 0. A MASK of 0 accepts every frame.
- Push: on an accepted frame_valid, the full 99-bit entry is written at the write pointer, and wptr and count advance.
- Full FIFO, no pop in the same cycle: the frame is dropped, the FIFO contents are unchanged, and ovf is set (sticky).
- Push and pop in the same cycle: both happen and count is unchanged. This includes the full case; there is no overflow then.
- Push and pop with count 0: the push happens and the pop is ignored.
- Flush together with a push: flush wins, the frame is discarded, and ovf is not set.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- irq = irqen & nempty.
- Reset values:
  - FIFO empty: count 0, pointers 0.
  - ovf 0, irqen 0, CODE 0, MASK 0.
  - q 0, irq 0.
  - Entry storage is not reset.
- Reset asserted mid-operation: all queued frames are lost immediately, without waiting for a clock edge.

## Timing
- Push latency: frame_valid at edge N gives an updated count/nempty and head after edge N+1. irq asserts in the cycle after that edge.
- Pop takes effect at the edge that samples the write. The next head is readable in the following cycle.
- Reads are combinational from the head entry and registers. The bus data_ready is tied high by the wrapper.
- Filter evaluation is combinational on the frame_* inputs in the frame_valid cycle. CODE/MASK writes in that same cycle are not used for that frame.
- frame_* inputs only need to be stable in the frame_valid cycle.

## Configuration
- CAN_RXF_FILTER_EN defined:
  - CODE/MASK registers exist.
  - The acceptance rule above applies.
- CAN_RXF_FILTER_EN undefined:
  - No CODE/MASK flops.
  - rs 4/5 read 0 and writes are ignored.
  - Every frame_valid is a push candidate.

## Test plan
- Single push: reset, then pulse frame_valid with id 0x123, ext 0, dlc 8, data 0x0807060504030201. Required:
  - rs0 = 0x00000123.
  - rs1[7:0] = 0x18.
  - rs2 = 0x04030201, rs3 = 0x08070605.
  - After a pop, rs1[16] = 0.
- Overflow: push 5 frames with ids 1..5, DEPTH 4, no pops. Required:
  - count = 4, full = 1, ovf = 1.
  - Four pops return ids 1, 2, 3, 4.
  - Writing d[2] clears ovf.
- Simultaneous push and pop when full: frame_valid in the same cycle as the pop write. Required:
  - count stays 4 and ovf stays 0.
  - The head advances.
  - The newest id is read last.
- Filter (macro on): CODE = 0x100, MASK = 0x7F0. Push ids 0x10F and 0x20F. Required: only 0x10F is queued (count 1). With the macro off, both are queued.
- Interrupt and flush:
  - Write irqen = 1, push one frame: irq rises one cycle after the push edge.
  - Flush in the same cycle as a new frame_valid: count 0, irq 0, ovf 0.
- Async reset: assert rst_n low between clock edges with 3 frames queued. Required: count, q and irq read 0 at once, with no clock edge needed.
